regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32x32 register file. Two producers, the ALU result path and the load/memory path, compete for the single register-file write port. This block grants one per cycle round-robin, drives the registered write port, and tracks which destination registers still have a write in flight so that the hazard logic can stall readers. It sits between the execute/memory stages and the register file's write inputs.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width (32 registers)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- alu_valid  in  1  ALU write-back request
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load write-back request
- mem_reg  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle
- wb_stall  in  1  suppress all grants this cycle
- issue_valid  in  1  instruction issued that will later write issue_reg
- issue_reg  in  ADDR_W  destination to mark pending
- chk_reg_a, chk_reg_b  in  ADDR_W  source registers to check
- busy_a, busy_b  out  1  pending write exists for chk_reg_a / chk_reg_b
- reg_write_en  out  1  register-file write enable
- write_reg  out  ADDR_W  register-file write index
- write_data  out  DATA_W  register-file write data

## Operation
- Handshake: a request transfers at a rising edge when valid and ready are both high. valid must not depend on ready. Once valid is asserted, reg and data are held stable until the transfer.
- ready is combinational from valid, wb_stall and the priority pointer. It is never high without the matching valid. At most one ready is high per cycle.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - The 1-bit pointer last_grant (0=ALU, 1=MEM) updates only on a transfer.
- wb_stall=1: both ready signals are 0 and the pointer holds.
- Register 0 handling:
  - A transfer to register 0 completes the handshake and updates the pointer.
  - It produces no reg_write_en.
  - issue_reg=0 never sets a pending bit.
- Scoreboard: pending[31:0].
  - issue_valid with issue_reg≠0 sets pending[issue_reg].
  - A transfer to register r clears pending[r].
  - If a set and a clear hit the same register in the same cycle, the set wins, because a new producer has been issued.
  - busy_x = pending[chk_reg_x], read combinationally from registered state.
- Output register: on each transfer to r≠0, load reg_write_en=1, write_reg=r and write_data=data. With no transfer, reg_write_en=0 and write_reg/write_data hold their values.

## Timing
- Reset values (asynchronous, while reset=0):
  - reg_write_en=0, write_reg=0, write_data=0.
  - pending=0, so busy_a=busy_b=0.
  - last_grant=1, so the ALU has priority first.
  - alu_ready=mem_ready=0 while reset is low.
- Latency: a transfer at edge N drives reg_write_en high during cycle N+1, for exactly one cycle per transfer. The register file commits on the falling edge within that cycle.
- The pending bit clears at edge N, so busy drops in the same cycle that reg_write_en is high.
- Throughput: one write per cycle. If both requesters are continuously valid, grants alternate, so each waits at most one cycle.
- Reset mid-operation: in-flight requests are dropped, pending bits are lost, and no write is issued in the cycle after reset deasserts.
- Two back-to-back transfers to the same register produce two consecutive writes; the later one wins in the register file.

## Structure
- Shared package regfile_pkg:
  - DATA_W, ADDR_W, NUM_REGS=32
  - REG_ZERO=0
  - requester id constants REQ_ALU=0, REQ_MEM=1
- Sub-module regfile_scoreboard:
  - Contains the pending vector with its set/clear priority and the two check ports.
  - The arbiter and output register stay in the top module.

## Test plan
- Reset low with alu_valid=1: alu_ready=0, reg_write_en=0, busy=0. After release, ALU write to r8=0x1 gives reg_write_en=1, write_reg=8, write_data=0x1 one cycle after the handshake.
- Both valid every cycle (ALU r9=0x2, MEM r18=0x3) for 4 cycles: grants are ALU, MEM, ALU, MEM; the write port alternates 9/18.
- issue_valid r20, then chk_reg_a=20: busy_a=1 until the MEM transfer to r20=0x4. busy_a=0 in the cycle reg_write_en=1.
- Same cycle as above: issue r22 and a transfer to r22. pending[22] stays set and busy remains 1.
- ALU transfer to r0=0xFFFF: alu_ready=1, no reg_write_en, pointer advances so MEM wins the next tie.
- wb_stall=1 for 3 cycles with both valid: no ready and no writes. Stall release: the grant follows the held pointer.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, register-zero index and requester ids for the write-back arbiter
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: producer requests, hazard check ports and register-file write port
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              wb_stall;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_reg;
  logic [ADDR_W-1:0] chk_reg_a, chk_reg_b;
  logic              busy_a, busy_b;
  logic              reg_write_en;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, wb_stall,
           issue_valid, issue_reg, chk_reg_a, chk_reg_b,
    output alu_ready, mem_ready, busy_a, busy_b, reg_write_en, write_reg, write_data
  );
  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data, wb_stall,
           issue_valid, issue_reg, chk_reg_a, chk_reg_b,
    input  alu_ready, mem_ready, busy_a, busy_b, reg_write_en, write_reg, write_data
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write bit per register; a same-cycle set beats the clear
module regfile_scoreboard #(
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_reg,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_reg,
  input  logic [ADDR_W-1:0] chk_a,
  input  logic [ADDR_W-1:0] chk_b,
  output logic              busy_a,
  output logic              busy_b
);
  import regfile_pkg::*;
  localparam int REGS = 2 ** ADDR_W;
  logic [REGS-1:0] pending, set_mask, clr_mask;
  always_comb begin
    set_mask = (set_en && set_reg != REG_ZERO) ? REGS'(1) << set_reg : '0;
    clr_mask = clr_en ? REGS'(1) << clr_reg : '0;
    busy_a = pending[chk_a];
    busy_b = pending[chk_b];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) pending <= '0;
    else pending <= (pending & ~clr_mask) | set_mask;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin grant of ALU/load write-backs onto the registered register-file write port
module regfile_wb_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input logic                clk,
  input logic                reset,
  regfile_wb_arbiter_if.slave bus
);
  import regfile_pkg::*;
  req_t              last_grant;
  logic              alu_gnt, mem_gnt, xfer, wr_en;
  logic [ADDR_W-1:0] xreg;
  logic [DATA_W-1:0] xdata;
  // reset gates the grants so nothing is accepted while state is held cleared
  always_comb begin
    alu_gnt = reset && !bus.wb_stall && bus.alu_valid && (!bus.mem_valid || last_grant == REQ_MEM);
    mem_gnt = reset && !bus.wb_stall && bus.mem_valid && (!bus.alu_valid || last_grant == REQ_ALU);
    xfer = alu_gnt || mem_gnt;
    xreg = mem_gnt ? bus.mem_reg : bus.alu_reg;
    xdata = mem_gnt ? bus.mem_data : bus.alu_data;
    wr_en = xfer && xreg != REG_ZERO;
  end
  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_grant <= REQ_MEM;
      bus.reg_write_en <= 1'b0;
      bus.write_reg <= '0;
      bus.write_data <= '0;
    end else begin
      if (xfer) last_grant <= mem_gnt ? REQ_MEM : REQ_ALU;
      bus.reg_write_en <= wr_en;
      if (wr_en) begin
        bus.write_reg <= xreg;
        bus.write_data <= xdata;
      end
    end
  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk,
    .reset,
    .set_en(bus.issue_valid),
    .set_reg(bus.issue_reg),
    .clr_en(xfer),
    .clr_reg(xreg),
    .chk_a(bus.chk_reg_a),
    .chk_b(bus.chk_reg_b),
    .busy_a(bus.busy_a),
    .busy_b(bus.busy_b)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus reset sequences for the write-back arbiter
module tb_regfile_wb_arbiter;
  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        st;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  ca, cb;
    logic        e_ar, e_mr, e_ba, e_bb, e_we;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  vec_t q[$];
  regfile_wb_arbiter_if bus();
  regfile_wb_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic add(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mr, input logic [31:0] md,
                     input logic st, input logic iv, input logic [4:0] ir,
                     input logic [4:0] ca, input logic [4:0] cb,
                     input logic e_ar, input logic e_mr, input logic e_ba, input logic e_bb,
                     input logic e_we, input logic [4:0] e_wr, input logic [31:0] e_wd);
    vec_t v;
    v = '{av, ar, ad, mv, mr, md, st, iv, ir, ca, cb, e_ar, e_mr, e_ba, e_bb, e_we, e_wr, e_wd};
    q.push_back(v);
  endtask
  task automatic drive(input vec_t v);
    bus.alu_valid = v.av; bus.alu_reg = v.ar; bus.alu_data = v.ad;
    bus.mem_valid = v.mv; bus.mem_reg = v.mr; bus.mem_data = v.md;
    bus.wb_stall = v.st; bus.issue_valid = v.iv; bus.issue_reg = v.ir;
    bus.chk_reg_a = v.ca; bus.chk_reg_b = v.cb;
  endtask
  task automatic chk_wr(input string nm, input logic we, input logic [4:0] wr, input logic [31:0] wd);
    chk({nm, " reg_write_en"}, 32'(bus.reg_write_en), 32'(we));
    chk({nm, " write_reg"}, 32'(bus.write_reg), 32'(wr));
    chk({nm, " write_data"}, bus.write_data, wd);
  endtask
  initial begin
    vec_t idle;
    idle = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
    drive(idle);
    add(1'b1,5'd8,32'h1,    1'b0,5'd0,32'h0,  1'b0, 1'b0,5'd0,  5'd8,5'd0,   1'b1,1'b0,1'b0,1'b0, 1'b1,5'd8,32'h1);
    add(1'b0,5'd0,32'h0,    1'b1,5'd17,32'h5, 1'b0, 1'b0,5'd0,  5'd17,5'd0,  1'b0,1'b1,1'b0,1'b0, 1'b1,5'd17,32'h5);
    add(1'b1,5'd9,32'h2,    1'b1,5'd18,32'h3, 1'b0, 1'b0,5'd0,  5'd9,5'd18,  1'b1,1'b0,1'b0,1'b0, 1'b1,5'd9,32'h2);
    add(1'b1,5'd9,32'h2,    1'b1,5'd18,32'h3, 1'b0, 1'b0,5'd0,  5'd9,5'd18,  1'b0,1'b1,1'b0,1'b0, 1'b1,5'd18,32'h3);
    add(1'b1,5'd9,32'h2,    1'b1,5'd18,32'h3, 1'b0, 1'b0,5'd0,  5'd9,5'd18,  1'b1,1'b0,1'b0,1'b0, 1'b1,5'd9,32'h2);
    add(1'b1,5'd9,32'h2,    1'b1,5'd18,32'h3, 1'b0, 1'b0,5'd0,  5'd9,5'd18,  1'b0,1'b1,1'b0,1'b0, 1'b1,5'd18,32'h3);
    add(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,  1'b0, 1'b1,5'd20, 5'd20,5'd0,  1'b0,1'b0,1'b0,1'b0, 1'b0,5'd18,32'h3);
    add(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,  1'b0, 1'b0,5'd0,  5'd20,5'd0,  1'b0,1'b0,1'b1,1'b0, 1'b0,5'd18,32'h3);
    add(1'b0,5'd0,32'h0,    1'b1,5'd20,32'h4, 1'b0, 1'b0,5'd0,  5'd20,5'd0,  1'b0,1'b1,1'b1,1'b0, 1'b1,5'd20,32'h4);
    add(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,  1'b0, 1'b0,5'd0,  5'd20,5'd0,  1'b0,1'b0,1'b0,1'b0, 1'b0,5'd20,32'h4);
    add(1'b1,5'd22,32'h7,   1'b0,5'd0,32'h0,  1'b0, 1'b1,5'd22, 5'd0,5'd22,  1'b1,1'b0,1'b0,1'b0, 1'b1,5'd22,32'h7);
    add(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,  1'b0, 1'b0,5'd0,  5'd0,5'd22,  1'b0,1'b0,1'b0,1'b1, 1'b0,5'd22,32'h7);
    add(1'b0,5'd0,32'h0,    1'b1,5'd22,32'h8, 1'b0, 1'b0,5'd0,  5'd0,5'd22,  1'b0,1'b1,1'b0,1'b1, 1'b1,5'd22,32'h8);
    add(1'b1,5'd0,32'hFFFF, 1'b0,5'd0,32'h0,  1'b0, 1'b1,5'd0,  5'd0,5'd22,  1'b1,1'b0,1'b0,1'b0, 1'b0,5'd22,32'h8);
    add(1'b1,5'd9,32'h2,    1'b1,5'd18,32'h3, 1'b0, 1'b0,5'd0,  5'd0,5'd0,   1'b0,1'b1,1'b0,1'b0, 1'b1,5'd18,32'h3);
    for (int k = 0; k < 3; k++)
      add(1'b1,5'd9,32'h2,  1'b1,5'd18,32'h3, 1'b1, 1'b0,5'd0,  5'd0,5'd0,   1'b0,1'b0,1'b0,1'b0, 1'b0,5'd18,32'h3);
    add(1'b1,5'd9,32'h2,    1'b1,5'd18,32'h3, 1'b0, 1'b0,5'd0,  5'd0,5'd0,   1'b1,1'b0,1'b0,1'b0, 1'b1,5'd9,32'h2);
    add(1'b1,5'd3,32'hA,    1'b0,5'd0,32'h0,  1'b0, 1'b0,5'd0,  5'd3,5'd0,   1'b1,1'b0,1'b0,1'b0, 1'b1,5'd3,32'hA);
    add(1'b1,5'd3,32'hB,    1'b0,5'd0,32'h0,  1'b0, 1'b0,5'd0,  5'd3,5'd0,   1'b1,1'b0,1'b0,1'b0, 1'b1,5'd3,32'hB);
    add(1'b0,5'd0,32'h0,    1'b0,5'd0,32'h0,  1'b0, 1'b0,5'd0,  5'd3,5'd0,   1'b0,1'b0,1'b0,1'b0, 1'b0,5'd3,32'hB);
    #2;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd8; bus.alu_data = 32'h1; bus.chk_reg_a = 5'd8;
    #1;
    chk("rst alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst busy_a", 32'(bus.busy_a), 32'd0);
    chk("rst busy_b", 32'(bus.busy_b), 32'd0);
    chk_wr("rst", 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    chk_wr("rst edge", 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      #1;
      chk($sformatf("v%0d alu_ready", i), 32'(bus.alu_ready), 32'(q[i].e_ar));
      chk($sformatf("v%0d mem_ready", i), 32'(bus.mem_ready), 32'(q[i].e_mr));
      chk($sformatf("v%0d busy_a", i), 32'(bus.busy_a), 32'(q[i].e_ba));
      chk($sformatf("v%0d busy_b", i), 32'(bus.busy_b), 32'(q[i].e_bb));
      @(posedge clk); #1;
      chk_wr($sformatf("v%0d", i), q[i].e_we, q[i].e_wr, q[i].e_wd);
      @(negedge clk);
    end
    drive(idle);
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd6; bus.alu_data = 32'hC;
    bus.issue_valid = 1'b1; bus.issue_reg = 5'd5; bus.chk_reg_a = 5'd5;
    #1;
    chk("mid alu_ready", 32'(bus.alu_ready), 32'd1);
    @(posedge clk); #1;
    chk_wr("mid pre", 1'b1, 5'd6, 32'hC);
    bus.issue_valid = 1'b0;
    #1;
    chk("mid busy_a", 32'(bus.busy_a), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_wr("mid async", 1'b0, 5'd0, 32'h0);
    chk("mid rst busy_a", 32'(bus.busy_a), 32'd0);
    chk("mid rst alu_ready", 32'(bus.alu_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(idle);
    bus.chk_reg_a = 5'd5;
    @(posedge clk); #1;
    chk_wr("post rst", 1'b0, 5'd0, 32'h0);
    chk("post rst busy_a", 32'(bus.busy_a), 32'd0);
    @(negedge clk);
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd9; bus.alu_data = 32'h2;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd18; bus.mem_data = 32'h3;
    #1;
    chk("post rst alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("post rst mem_ready", 32'(bus.mem_ready), 32'd0);
    @(posedge clk); #1;
    chk_wr("post rst tie", 1'b1, 5'd9, 32'h2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
